// File: rtl/emu_scan_ram.sv
// emu_scan_ram: scannable synchronous RAM for emulator DUT memories.
// While the DUT runs (halt=0) it serves one read port (1-cycle latency,
// read-old-on-collision) and one write port. While halted, a scan window
// dumps the array onto sdo or loads it from sdi, one word per cycle.
// Optional feature macro: EMU_SCAN_RAM_CSUM_EN adds the scan_csum output,
// an XOR accumulator of every word streamed in or out during a window.
module emu_scan_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int SCAN_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  halt,
  input  logic                  ren,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  scan,
  input  logic                  dir,
  input  logic [SCAN_WIDTH-1:0] sdi,
  output logic [SCAN_WIDTH-1:0] sdo
`ifdef EMU_SCAN_RAM_CSUM_EN
  ,
  output logic [SCAN_WIDTH-1:0] scan_csum
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_DUMP_PRIME  = 3'd1;
  localparam logic [2:0] S_DUMP_STREAM = 3'd2;
  localparam logic [2:0] S_LOAD        = 3'd3;
  localparam logic [2:0] S_LOAD_FLUSH  = 3'd4;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [SCAN_WIDTH-1:0] sdo_q, sdo_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;

  logic                  scan_ok;
  logic                  dump_rd;
  logic                  commit;
  logic                  func_wr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  unused_sdi;

  // Bits of sdi above DATA_WIDTH are deliberately ignored.
  assign unused_sdi = ^sdi;

  // Shared read port and write-port arbitration; dump reads only happen
  // with halt=1, so they never collide with a functional read.
  always_comb begin
    scan_ok = scan & halt;
    dump_rd = scan_ok && (state_q == S_DUMP_PRIME || state_q == S_DUMP_STREAM);
    // The captured load word is written on the next scan edge, or by the
    // flush state once the window has closed.
    commit  = pend_valid_q &&
              ((state_q == S_LOAD && scan_ok) || state_q == S_LOAD_FLUSH);
    // A scan commit owns the write port; a functional write arriving in the
    // same cycle (halt dropped mid-window) loses.
    func_wr = !halt && wen && !commit;
    rd_addr = dump_rd ? cnt_q : raddr;
    rd_word = mem[rd_addr];
  end

  // Next-state logic for the scan FSM, counter, sdo and functional read data.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    sdo_d        = sdo_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    rdata_d      = (!halt && ren) ? rd_word : rdata_q;

    case (state_q)
      S_IDLE: begin
        if (scan_ok) begin
          cnt_d = '0;
          if (dir) begin
            state_d      = S_LOAD;
            pend_valid_d = 1'b1;
            pend_data_d  = sdi[DATA_WIDTH-1:0];
          end else begin
            state_d = S_DUMP_PRIME;
          end
        end
      end
      S_DUMP_PRIME, S_DUMP_STREAM: begin
        if (scan_ok) begin
          sdo_d                 = '0;
          sdo_d[DATA_WIDTH-1:0] = rd_word;
          cnt_d                 = cnt_q + 1'b1;
          state_d               = S_DUMP_STREAM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (scan_ok) begin
          pend_data_d = sdi[DATA_WIDTH-1:0];
          cnt_d       = cnt_q + 1'b1;
        end else begin
          state_d = S_LOAD_FLUSH;
        end
      end
      S_LOAD_FLUSH: begin
        pend_valid_d = 1'b0;
        state_d      = S_IDLE;
      end
      default: begin
        state_d      = S_IDLE;
        pend_valid_d = 1'b0;
      end
    endcase
  end

  // Control and output registers; reset abandons any window immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rdata_q      <= '0;
      sdo_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      sdo_q        <= sdo_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
    end
  end

  // Array write port: scan commit or functional write.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset on purpose; contents survive rst_n and a
    // reset term would also prevent RAM inference.
    if (commit) begin
      mem[cnt_q] <= pend_data_q;
    end else if (func_wr) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = rdata_q;
  assign sdo   = sdo_q;

`ifdef EMU_SCAN_RAM_CSUM_EN
  logic [SCAN_WIDTH-1:0] csum_q, csum_d;
  logic [SCAN_WIDTH-1:0] pend_ext;

  // Checksum: cleared when a window opens, folds in each streamed word.
  always_comb begin
    pend_ext                 = '0;
    pend_ext[DATA_WIDTH-1:0] = pend_data_q;
    csum_d                   = csum_q;
    if (state_q == S_IDLE && scan_ok) begin
      csum_d = '0;
    end else if (dump_rd) begin
      csum_d = csum_q ^ sdo_d;
    end else if (commit) begin
      csum_d = csum_q ^ pend_ext;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign scan_csum = csum_q;
`endif

endmodule

// File: tb/tb_emu_scan_ram.sv
// Self-checking bench for emu_scan_ram. A word-level array model tracks the
// RAM contents; expected rdata, sdo and checksum come from that model.
module tb_emu_scan_ram;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int SW    = 64;
  localparam int DEPTH = 1 << AW;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          halt  = 1'b0;
  logic          ren   = 1'b0;
  logic          wen   = 1'b0;
  logic          scan  = 1'b0;
  logic          dir   = 1'b0;
  logic [AW-1:0] raddr = '0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic [SW-1:0] sdi   = '0;
  logic [DW-1:0] rdata;
  logic [SW-1:0] sdo;
`ifdef EMU_SCAN_RAM_CSUM_EN
  logic [SW-1:0] scan_csum;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW-1:0] exp_rdata = '0;
  logic [SW-1:0] exp_sdo   = '0;
  logic [SW-1:0] exp_csum  = '0;

  emu_scan_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SCAN_WIDTH(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .halt  (halt),
    .ren   (ren),
    .raddr (raddr),
    .rdata (rdata),
    .wen   (wen),
    .waddr (waddr),
    .wdata (wdata),
    .scan  (scan),
    .dir   (dir),
    .sdi   (sdi),
    .sdo   (sdo)
`ifdef EMU_SCAN_RAM_CSUM_EN
    ,
    .scan_csum (scan_csum)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic func_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    halt  = 1'b0;
    ren   = 1'b0;
    wen   = 1'b1;
    waddr = a;
    wdata = d;
    step();
    exp_mem[a] = d;
    wen = 1'b0;
  endtask

  task automatic func_read_check(input logic [AW-1:0] a, input string tag);
    halt  = 1'b0;
    ren   = 1'b1;
    raddr = a;
    step();
    exp_rdata = exp_mem[a];
    ren = 1'b0;
    n_cmp++;
    if (rdata !== exp_rdata) begin
      n_err++;
      $display("FAIL %s addr=%0d: got %h want %h", tag, a, rdata, exp_rdata);
    end
  endtask

  // Opens a dump window from IDLE (halt=1), checks n words, closes it.
  task automatic dump_check(input int n_words, input string tag);
    halt     = 1'b1;
    dir      = 1'b0;
    scan     = 1'b1;
    exp_csum = '0;
    step();
    for (int k = 0; k < n_words; k++) begin
      if ($urandom_range(0, 3) == 0) dir = ~dir;
      step();
      exp_sdo  = SW'(exp_mem[k % DEPTH]);
      exp_csum = exp_csum ^ exp_sdo;
      n_cmp++;
      if (sdo !== exp_sdo) begin
        n_err++;
        $display("FAIL %s word=%0d: got %h want %h", tag, k, sdo, exp_sdo);
      end
    end
    scan = 1'b0;
    dir  = 1'b0;
    step();
    n_cmp++;
    if (sdo !== exp_sdo) begin
      n_err++;
      $display("FAIL %s sdo_hold: got %h want %h", tag, sdo, exp_sdo);
    end
    step();
  endtask

  // Loads n words (mode 0: 0xFFFF_FFFF_0000_00AA+i, else random), closes.
  task automatic load_window(input int n_words, input int mode);
    halt     = 1'b1;
    dir      = 1'b1;
    scan     = 1'b1;
    exp_csum = '0;
    for (int i = 0; i < n_words; i++) begin
      if (mode == 0) sdi = 64'hFFFF_FFFF_0000_00AA + 64'(i);
      else           sdi = {$urandom, $urandom};
      step();
      if (i > 0 && $urandom_range(0, 3) == 0) dir = ~dir;
      exp_mem[i % DEPTH] = sdi[DW-1:0];
      exp_csum = exp_csum ^ SW'(sdi[DW-1:0]);
    end
    scan = 1'b0;
    dir  = 1'b0;
    sdi  = {$urandom, $urandom};
    step();
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    n_cmp++;
    if (rdata !== '0) begin
      n_err++;
      $display("FAIL reset_rdata: got %h want 0", rdata);
    end
    n_cmp++;
    if (sdo !== '0) begin
      n_err++;
      $display("FAIL reset_sdo: got %h want 0", sdo);
    end
`ifdef EMU_SCAN_RAM_CSUM_EN
    n_cmp++;
    if (scan_csum !== '0) begin
      n_err++;
      $display("FAIL reset_csum: got %h want 0", scan_csum);
    end
`endif
    rst_n = 1'b1;
    step();
    exp_rdata = '0;
    exp_sdo   = '0;
  endtask

  task automatic test_functional();
    for (int i = 0; i < DEPTH; i++) func_write(AW'(i), $urandom);
    func_write(AW'(5), 32'hDEADBEEF);
    func_read_check(AW'(5), "func_read");
    n_cmp++;
    if (rdata !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL func_read_const: got %h want deadbeef", rdata);
    end
    // Same-address read and write in one cycle returns the old word.
    ren = 1'b1; raddr = AW'(5);
    wen = 1'b1; waddr = AW'(5); wdata = 32'h1;
    step();
    ren = 1'b0; wen = 1'b0;
    n_cmp++;
    if (rdata !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL same_addr_old: got %h want deadbeef", rdata);
    end
    exp_mem[5] = 32'h1;
    func_read_check(AW'(5), "read_after_same_addr");
    // Random traffic concentrated on few addresses to hit collisions.
    for (int c = 0; c < 300; c++) begin
      ren   = 1'($urandom);
      wen   = 1'($urandom);
      raddr = AW'($urandom_range(0, 15));
      waddr = AW'($urandom_range(0, 15));
      wdata = $urandom;
      step();
      if (ren) exp_rdata = exp_mem[raddr];
      if (wen) exp_mem[waddr] = wdata;
      n_cmp++;
      if (rdata !== exp_rdata) begin
        n_err++;
        $display("FAIL func_random cyc=%0d: got %h want %h", c, rdata, exp_rdata);
      end
    end
    ren = 1'b0;
    wen = 1'b0;
  endtask

  task automatic test_dump();
    for (int i = 0; i < DEPTH; i++) func_write(AW'(i), DW'(i + 32'h100));
    halt = 1'b1;
    step();
    dump_check(DEPTH + 3, "dump_wrap");
  endtask

  task automatic test_load_roundtrip();
    load_window(DEPTH, 0);
    dump_check(DEPTH, "roundtrip_dump");
    halt = 1'b0;
    step();
    func_read_check(AW'(0), "roundtrip_read0");
    n_cmp++;
    if (rdata !== 32'h0000_00AA) begin
      n_err++;
      $display("FAIL roundtrip_read0_const: got %h want 000000aa", rdata);
    end
    halt = 1'b1;
    step();
    begin
      int n;
      n = $urandom_range(1, 40);
      load_window(n, 1);
      dump_check(n + 4, "partial_load_dump");
    end
  endtask

  task automatic test_gating();
    logic [AW-1:0] addrs [8];
    halt = 1'b0; ren = 1'b0; wen = 1'b0;
    scan = 1'b1; dir = 1'b1; sdi = 64'h55;
    for (int c = 0; c < 8; c++) begin
      step();
      n_cmp++;
      if (sdo !== exp_sdo || rdata !== exp_rdata) begin
        n_err++;
        $display("FAIL gate_scan cyc=%0d: got sdo=%h rdata=%h want sdo=%h rdata=%h",
                 c, sdo, rdata, exp_sdo, exp_rdata);
      end
    end
    scan = 1'b0; dir = 1'b0;
    step();
    for (int i = 0; i < 8; i++) func_read_check(AW'(i), "gate_scan_array");
    halt = 1'b1;
    step();
    for (int c = 0; c < 8; c++) begin
      addrs[c] = AW'($urandom);
      wen = 1'b1; waddr = addrs[c]; wdata = $urandom;
      ren = 1'b1; raddr = AW'($urandom);
      step();
      n_cmp++;
      if (rdata !== exp_rdata) begin
        n_err++;
        $display("FAIL gate_halt_rdata cyc=%0d: got %h want %h", c, rdata, exp_rdata);
      end
    end
    wen = 1'b0; ren = 1'b0;
    for (int c = 0; c < 8; c++) func_read_check(addrs[c], "gate_halt_array");
  endtask

  task automatic test_abort();
    logic [DW-1:0] new_w [4];
    halt = 1'b1;
    step();
    // Dump aborted while word 3 would be next.
    dir = 1'b0; scan = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (sdo !== SW'(exp_mem[k])) begin
        n_err++;
        $display("FAIL abort_dump_pre word=%0d: got %h want %h", k, sdo, SW'(exp_mem[k]));
      end
    end
    rst_n = 1'b0;
    #1;
    exp_sdo = '0; exp_rdata = '0;
    n_cmp++;
    if (sdo !== '0 || rdata !== '0) begin
      n_err++;
      $display("FAIL abort_dump_reset: got sdo=%h rdata=%h want 0", sdo, rdata);
    end
    scan = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    dump_check(3, "after_dump_abort");
    // Load aborted by reset with word 3 captured but not committed.
    dir = 1'b1; scan = 1'b1;
    for (int i = 0; i < 4; i++) begin
      new_w[i] = $urandom;
      sdi = {$urandom, new_w[i]};
      step();
    end
    rst_n = 1'b0;
    scan  = 1'b0;
    dir   = 1'b0;
    for (int i = 0; i < 3; i++) exp_mem[i] = new_w[i];
    exp_sdo = '0; exp_rdata = '0;
    step();
    rst_n = 1'b1;
    step();
    dump_check(6, "after_load_abort");
  endtask

`ifdef EMU_SCAN_RAM_CSUM_EN
  task automatic test_csum();
    for (int i = 0; i < 4; i++) func_write(AW'(i), DW'(1) << i);
    halt = 1'b1;
    step();
    dir = 1'b0; scan = 1'b1;
    step();
    n_cmp++;
    if (scan_csum !== '0) begin
      n_err++;
      $display("FAIL csum_clear_on_open: got %h want 0", scan_csum);
    end
    for (int k = 0; k < 4; k++) step();
    exp_sdo = SW'(exp_mem[3]);
    scan = 1'b0;
    step();
    step();
    n_cmp++;
    if (scan_csum !== 64'hF) begin
      n_err++;
      $display("FAIL csum_dump4: got %h want f", scan_csum);
    end
    load_window(3, 1);
    step();
    n_cmp++;
    if (scan_csum !== exp_csum) begin
      n_err++;
      $display("FAIL csum_load: got %h want %h", scan_csum, exp_csum);
    end
    dump_check(20, "csum_dump_data");
    n_cmp++;
    if (scan_csum !== exp_csum) begin
      n_err++;
      $display("FAIL csum_dump20: got %h want %h", scan_csum, exp_csum);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_functional();
    test_dump();
    test_load_roundtrip();
    test_gating();
    test_abort();
`ifdef EMU_SCAN_RAM_CSUM_EN
    test_csum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
